// File: rtl/reg_bank.sv
// reg_bank: NUM_REGS x WIDTH register file with lane loads, clear, inc/dec,
// two combinational read ports and per-register zero/sticky-overflow flags.
// Optional build macro: REG_BANK_SATURATE_EN (inc/dec saturate instead of wrap).
module reg_bank #(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned LANE_W   = 8,
  parameter int unsigned NUM_REGS = 4,
  localparam int unsigned LANES   = WIDTH / LANE_W,
  localparam int unsigned LSW     = (LANES > 1) ? $clog2(LANES) : 1,
  localparam int unsigned RSW     = $clog2(NUM_REGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [LANE_W-1:0]   I,
  input  logic [1:0]          FunSel,
  input  logic [LSW-1:0]      lane_sel,
  input  logic [NUM_REGS-1:0] en,
  input  logic [RSW-1:0]      rd_sel_a,
  input  logic [RSW-1:0]      rd_sel_b,
  output logic [WIDTH-1:0]    out_a,
  output logic [WIDTH-1:0]    out_b,
  output logic [NUM_REGS-1:0] zero,
  output logic [NUM_REGS-1:0] ovf
);

  localparam int unsigned RD_DEPTH = 2 ** RSW;

  localparam logic [1:0] OP_CLR = 2'b00;
  localparam logic [1:0] OP_LD  = 2'b01;
  localparam logic [1:0] OP_DEC = 2'b10;
  localparam logic [1:0] OP_INC = 2'b11;

  if ((WIDTH % LANE_W) != 0) begin : g_chk_width
    $error("reg_bank: WIDTH must be a multiple of LANE_W");
  end
  if (NUM_REGS < 2) begin : g_chk_regs
    $error("reg_bank: NUM_REGS must be at least 2");
  end

  logic [WIDTH-1:0]    regs     [NUM_REGS];
  logic [WIDTH-1:0]    nxt_val  [NUM_REGS];
  logic [NUM_REGS-1:0] nxt_zero;
  logic [NUM_REGS-1:0] nxt_ovf;
  logic [WIDTH-1:0]    rd_tbl   [RD_DEPTH];

  // Per-register next value and flags; disabled registers hold.
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      nxt_val[r] = regs[r];
      nxt_ovf[r] = ovf[r];
      if (en[r]) begin
        case (FunSel)
          OP_CLR: begin
            nxt_val[r] = '0;
            nxt_ovf[r] = 1'b0;
          end
          OP_LD: begin
            for (int k = 0; k < LANES; k++) begin
              if (lane_sel == LSW'(k)) begin
                nxt_val[r][k*LANE_W +: LANE_W] = I;
              end
            end
          end
          OP_DEC: begin
            if (regs[r] == '0) begin
              nxt_ovf[r] = 1'b1;
`ifdef REG_BANK_SATURATE_EN
              nxt_val[r] = '0;
`else
              nxt_val[r] = '1;
`endif
            end else begin
              nxt_val[r] = regs[r] - WIDTH'(1);
            end
          end
          OP_INC: begin
            if (&regs[r]) begin
              nxt_ovf[r] = 1'b1;
`ifdef REG_BANK_SATURATE_EN
              nxt_val[r] = '1;
`else
              nxt_val[r] = '0;
`endif
            end else begin
              nxt_val[r] = regs[r] + WIDTH'(1);
            end
          end
          default: nxt_val[r] = regs[r];
        endcase
      end
      nxt_zero[r] = (nxt_val[r] == '0);
    end
  end

  // State update; zero flag tracks the value written on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        regs[r] <= '0;
      end
      zero <= '1;
      ovf  <= '0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        regs[r] <= nxt_val[r];
      end
      zero <= nxt_zero;
      ovf  <= nxt_ovf;
    end
  end

  // Read table padded to the full select range; unused selects read as 0.
  for (genvar i = 0; i < RD_DEPTH; i++) begin : g_rd
    if (i < NUM_REGS) begin : g_live
      assign rd_tbl[i] = regs[i];
    end else begin : g_pad
      assign rd_tbl[i] = '0;
    end
  end

  assign out_a = rd_tbl[rd_sel_a];
  assign out_b = rd_tbl[rd_sel_b];

endmodule

// File: tb/tb_reg_bank.sv
// Self-checking bench for reg_bank: directed scenarios plus randomized
// operations compared against an arithmetic model of the register bank.
module tb_reg_bank;

  localparam int NR   = 4;
  localparam int MAXV = 16'hFFFF;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  I;
  logic [1:0]  FunSel;
  logic [0:0]  lane_sel;
  logic [3:0]  en;
  logic [1:0]  rd_sel_a, rd_sel_b;
  logic [15:0] out_a, out_b;
  logic [3:0]  zero, ovf;

  logic [2:0]  en3;
  logic [1:0]  rd3_a, rd3_b;
  logic [15:0] out3_a, out3_b;
  logic [2:0]  zero3, ovf3;

  int checks = 0;
  int errors = 0;

  int m_reg [NR];
  bit m_ovf [NR];

  always #5 clk = ~clk;

  reg_bank dut (
    .clk(clk), .rst(rst), .I(I), .FunSel(FunSel), .lane_sel(lane_sel),
    .en(en), .rd_sel_a(rd_sel_a), .rd_sel_b(rd_sel_b),
    .out_a(out_a), .out_b(out_b), .zero(zero), .ovf(ovf)
  );

  reg_bank #(.NUM_REGS(3)) dut3 (
    .clk(clk), .rst(rst), .I(I), .FunSel(FunSel), .lane_sel(lane_sel),
    .en(en3), .rd_sel_a(rd3_a), .rd_sel_b(rd3_b),
    .out_a(out3_a), .out_b(out3_b), .zero(zero3), .ovf(ovf3)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Behavioural effect of one clock edge, from the operation rules.
  task automatic model_step();
    if (rst) begin
      for (int r = 0; r < NR; r++) begin
        m_reg[r] = 0;
        m_ovf[r] = 0;
      end
      return;
    end
    for (int r = 0; r < NR; r++) begin
      if (!en[r]) continue;
      case (FunSel)
        2'b00: begin m_reg[r] = 0; m_ovf[r] = 0; end
        2'b01: begin
          int sh = 8 * int'(lane_sel);
          m_reg[r] = (m_reg[r] & ~(255 << sh) & MAXV) | (int'(I) << sh);
        end
        2'b11: begin
          if (m_reg[r] == MAXV) begin
            m_ovf[r] = 1;
`ifndef REG_BANK_SATURATE_EN
            m_reg[r] = 0;
`endif
          end else m_reg[r] = m_reg[r] + 1;
        end
        default: begin
          if (m_reg[r] == 0) begin
            m_ovf[r] = 1;
`ifndef REG_BANK_SATURATE_EN
            m_reg[r] = MAXV;
`endif
          end else m_reg[r] = m_reg[r] - 1;
        end
      endcase
    end
  endtask

  task automatic check_all();
    logic [3:0] ez, eo;
    for (int r = 0; r < NR; r++) begin
      rd_sel_a = 2'(r);
      rd_sel_b = 2'((r + 1) % NR);
      #1;
      check("out_a", 32'(out_a), 32'(m_reg[r]));
      check("out_b", 32'(out_b), 32'(m_reg[(r + 1) % NR]));
      ez[r] = (m_reg[r] == 0);
      eo[r] = m_ovf[r];
    end
    check("zero", 32'(zero), 32'(ez));
    check("ovf", 32'(ovf), 32'(eo));
  endtask

  task automatic cycle(input logic r, input logic [1:0] fs, input logic [3:0] e,
                       input logic ls, input logic [7:0] d);
    rst = r; FunSel = fs; en = e; lane_sel = ls; I = d;
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  initial begin
    rst = 1'b0; I = '0; FunSel = '0; lane_sel = '0; en = '0;
    rd_sel_a = '0; rd_sel_b = '0; en3 = '0; rd3_a = '0; rd3_b = '0;
    for (int r = 0; r < NR; r++) begin m_reg[r] = 0; m_ovf[r] = 0; end

    // Reset state
    cycle(1'b1, 2'b11, 4'b1111, 1'b0, 8'h00);

    // Lane load into register 1 (and all of the 3-register instance)
    en3 = 3'b111;
    cycle(1'b0, 2'b01, 4'b0010, 1'b0, 8'h34);
    en3 = 3'b000;
    rd3_a = 2'd3; rd3_b = 2'd2; #1;
    check("out3_a_oob", 32'(out3_a), 32'h0);
    check("out3_b", 32'(out3_b), 32'h0034);
    cycle(1'b0, 2'b01, 4'b0010, 1'b1, 8'h12);
    check("reg1_1234", 32'(m_reg[1]), 32'h1234);

    // Wrap / sticky overflow / clear on register 2
    cycle(1'b0, 2'b01, 4'b0100, 1'b0, 8'hFF);
    cycle(1'b0, 2'b01, 4'b0100, 1'b1, 8'hFF);
    cycle(1'b0, 2'b11, 4'b0100, 1'b0, 8'h00);
    cycle(1'b0, 2'b10, 4'b0100, 1'b0, 8'h00);
    cycle(1'b0, 2'b00, 4'b0100, 1'b0, 8'h00);

    // Limits on registers 0 (at 0) and 3 (at FFFF)
    cycle(1'b0, 2'b10, 4'b0001, 1'b0, 8'h00);
    cycle(1'b0, 2'b01, 4'b1000, 1'b0, 8'hFF);
    cycle(1'b0, 2'b01, 4'b1000, 1'b1, 8'hFF);
    cycle(1'b0, 2'b11, 4'b1000, 1'b0, 8'h00);

    // Multi-enable count from reset, then hold
    cycle(1'b1, 2'b00, 4'b0000, 1'b0, 8'h00);
    for (int i = 0; i < 3; i++) cycle(1'b0, 2'b11, 4'b1011, 1'b0, 8'h00);
    cycle(1'b0, 2'b00, 4'b0000, 1'b0, 8'h00);

    // Read aliasing while counting, then reset mid-sequence
    rd_sel_a = 2'd1; rd_sel_b = 2'd1;
    rst = 1'b0; FunSel = 2'b11; en = 4'b1111;
    @(posedge clk); model_step(); #1;
    check("alias_a", 32'(out_a), 32'(m_reg[1]));
    check("alias_b", 32'(out_b), 32'(m_reg[1]));
    cycle(1'b1, 2'b11, 4'b1111, 1'b0, 8'h00);

    // Randomized operations
    for (int n = 0; n < 400; n++) begin
      logic [7:0] d;
      d = ($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom);
      cycle(($urandom_range(0, 49) == 0), 2'($urandom), 4'($urandom),
            1'($urandom), d);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_bank.md
# reg_bank

Parametrised bank of NUM_REGS general-purpose registers, each WIDTH bits wide, loaded one LANE_W-bit lane at a time from a narrow input bus. Registers can also be cleared, incremented and decremented. The block generalises the single 16-bit byte-loadable counter register to multiple registers with per-register enables, arbitrary width and lane count, two read ports, and per-register zero/overflow status. It sits in the datapath as the general register file feeding the ALU and the address logic.

## Interface
- WIDTH, 16, register width in bits; must be a multiple of LANE_W.
- LANE_W, 8, input bus width and load granularity.
- NUM_REGS, 4, number of registers; must be at least 2.
- Derived: LANES = WIDTH/LANE_W; LSW = max(1, clog2(LANES)); RSW = clog2(NUM_REGS).
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset; has priority over all other inputs.
- I  in  LANE_W  load data.
- FunSel  in  2  operation: 00 clear, 01 load lane, 10 decrement, 11 increment.
- lane_sel  in  LSW  lane targeted by a load; lane k covers bits [k*LANE_W +: LANE_W].
- en  in  NUM_REGS  per-register enable; bit r set means register r executes FunSel this cycle.
- rd_sel_a  in  RSW  read port A select.
- rd_sel_b  in  RSW  read port B select.
- out_a  out  WIDTH  contents of register rd_sel_a.
- out_b  out  WIDTH  contents of register rd_sel_b.
- zero  out  NUM_REGS  bit r high when register r equals 0 (registered).
- ovf  out  NUM_REGS  sticky bit r set on an increment or decrement past a limit.

## Operation
- Reset: every register is 0, zero is all-ones and ovf is all-zeros.
- For each r with en[r]=1, the selected operation applies to register r. Registers with en[r]=0 hold their value and flags.
- Several en bits may be set in one cycle; all selected registers execute the same FunSel in parallel.
- 00 clear: register becomes 0 and ovf[r] clears.
- 01 load: only lane lane_sel is replaced by I; other lanes hold. If lane_sel ≥ LANES, the register is unchanged. Loads leave ovf unchanged.
- 11 increment: adds 1 modulo 2^WIDTH. At all-ones the result wraps to 0 and ovf[r] sets.
- 10 decrement: subtracts 1 modulo 2^WIDTH. At 0 the result wraps to all-ones and ovf[r] sets.
- ovf[r] clears only on reset or on a clear of register r.
- zero[r] is registered with the same edge as the data, so it always matches the register's current value.
- Read ports are combinational from register state. If rd_sel ≥ NUM_REGS, the port outputs 0.
- Both ports may select the same register.

## Timing
- Write latency is one cycle. An operation sampled at edge n is visible on out_a/out_b, zero and ovf after edge n.
- There is no read-during-write bypass: a port reads the old value until the edge.
- Asserting rst in any cycle overrides FunSel/en in that cycle and produces the reset state after the edge.
- Operations are not persistent. Holding en high repeats the operation every cycle; for example, increment counts by 1 per clock.

## Configuration
- REG_BANK_SATURATE_EN defined:
  - Increment at all-ones holds all-ones.
  - Decrement at 0 holds 0.
  - In both cases ovf[r] still sets.
- REG_BANK_SATURATE_EN undefined: increment and decrement wrap as described under Operation.
- Macro absent is the default build.

## Test plan
- Reset, then default parameters: rst=1 for one cycle -> all reads 0000, zero=4'b1111, ovf=0.
- Lane load: en=4'b0010, FunSel=01, lane_sel=0, I=34, then lane_sel=1, I=12 -> register 1 = 1234, zero[1]=0, other registers 0000.
- Wrap: load register 2 with FFFF, then increment once -> 0000, zero[2]=1, ovf[2]=1. A following decrement -> FFFF with ovf[2] still 1. A clear then gives 0000 with ovf[2]=0.
- Saturation build (REG_BANK_SATURATE_EN): register 0 = 0000, decrement -> 0000, ovf[0]=1. Register 3 = FFFF, increment -> FFFF, ovf[3]=1.
- Multi-enable and hold: en=4'b1011, FunSel=11 for 3 cycles from reset -> registers 0, 1 and 3 = 0003, register 2 = 0000. Then en=0 with FunSel=00 -> all values unchanged.
- Reset mid-sequence and read aliasing: rd_sel_a=rd_sel_b=1 during counting shows identical values. Asserting rst while en=4'b1111, FunSel=11 -> all registers 0000 on the next cycle. rd_sel_a out of range with NUM_REGS=3 -> out_a=0.
